// File: rtl/sevenseg_reader_if.sv
// ---------------------------------------------------------------------------
// sevenseg_reader_if
// Bus between a multiplexed two-digit seven-segment source and the reader.
//   seg_in  [6:0] segment pattern, bit0 = a ... bit6 = g
//   dig_sel [1:0] 2'b01 = ones digit, 2'b10 = tens digit
//   strobe        seg_in/dig_sel valid this cycle
//   v_out   [3:0] last good decoded value
//   valid         one-cycle pulse, new value on v_out
//   err           one-cycle pulse, frame rejected
//   busy          ones digit held, waiting for tens
// master = display/stimulus side, slave = reader side.
// ---------------------------------------------------------------------------
interface sevenseg_reader_if;
    logic [6:0] seg_in;
    logic [1:0] dig_sel;
    logic       strobe;
    logic [3:0] v_out;
    logic       valid;
    logic       err;
    logic       busy;

    modport master (
        output seg_in, dig_sel, strobe,
        input  v_out, valid, err, busy
    );

    modport slave (
        input  seg_in, dig_sel, strobe,
        output v_out, valid, err, busy
    );
endinterface

// File: rtl/sevenseg_reader.sv
// ---------------------------------------------------------------------------
// sevenseg_reader
// Decodes a time-multiplexed two-digit seven-segment bus back to a 4-bit
// value. A ones digit is captured, paired with the following tens digit,
// range-checked (0..15) and reported with a registered valid or err pulse.
//
// Parameters:
//   TIMEOUT        max cycles from ones acceptance to tens sample (2..255)
//   SEG_ACTIVE_LOW 1 = seg_in is inverted before decoding
// Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset
//   bus    sevenseg_reader_if.slave (seg_in/dig_sel/strobe in,
//          v_out/valid/err/busy out)
// Build option:
//   SEVENSEG_READER_STABLE_EN  when defined, a good frame is only published
//   (v_out + valid) if it matches the previous good frame's value.
// ---------------------------------------------------------------------------
module sevenseg_reader #(
    parameter int TIMEOUT        = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input logic              clk_i,
    input logic              rst_i,
    sevenseg_reader_if.slave bus
);

    typedef enum logic {WAIT_ONES, WAIT_TENS} state_e;

    // Timer value in the last idle cycle before the timeout fires; the err
    // then lands TIMEOUT cycles after the ones strobe cycle.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 2);

    state_e     state_q, state_d;
    logic [3:0] ones_q, ones_d;
    logic [7:0] timer_q, timer_d;
    logic [3:0] v_out_q, v_out_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
`ifdef SEVENSEG_READER_STABLE_EN
    logic [3:0] cand_q, cand_d;
    logic       cand_vld_q, cand_vld_d;
`endif

    logic [6:0] seg;
    logic       ones_ok;
    logic [3:0] ones_dig;
    logic       tens_ok;
    logic       tens_dig;
    logic [4:0] value;
    logic       good;

    // Segment decode
    always_comb begin
        seg      = SEG_ACTIVE_LOW ? ~bus.seg_in : bus.seg_in;
        ones_ok  = 1'b1;
        ones_dig = 4'd0;
        case (seg)
            7'h3F: ones_dig = 4'd0;
            7'h06: ones_dig = 4'd1;
            7'h5B: ones_dig = 4'd2;
            7'h4F: ones_dig = 4'd3;
            7'h66: ones_dig = 4'd4;
            7'h6D: ones_dig = 4'd5;
            7'h7D: ones_dig = 4'd6;
            7'h07: ones_dig = 4'd7;
            7'h7F: ones_dig = 4'd8;
            7'h6F: ones_dig = 4'd9;
            default: ones_ok = 1'b0;
        endcase
        tens_ok  = 1'b1;
        tens_dig = 1'b0;
        case (seg)
            7'h3F, 7'h00: tens_dig = 1'b0;   // blank tens means zero
            7'h06:        tens_dig = 1'b1;
            default:      tens_ok  = 1'b0;
        endcase
        value = tens_dig ? (5'd10 + {1'b0, ones_q}) : {1'b0, ones_q};
    end

    // Next state / outputs
    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        timer_d = timer_q;
        v_out_d = v_out_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        good    = 1'b0;
`ifdef SEVENSEG_READER_STABLE_EN
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
`endif

        if (bus.strobe) begin
            case (bus.dig_sel)
                2'b01: begin
                    // Also restarts a pending frame from WAIT_TENS.
                    if (ones_ok) begin
                        ones_d  = ones_dig;
                        timer_d = 8'd0;
                        state_d = WAIT_TENS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_ONES;
                    end
                end
                2'b10: begin
                    // A lone tens digit in WAIT_ONES is silently dropped.
                    if (state_q == WAIT_TENS) begin
                        state_d = WAIT_ONES;
                        if (tens_ok && value <= 5'd15) good  = 1'b1;
                        else                           err_d = 1'b1;
                    end
                end
                default: begin
                    err_d   = 1'b1;
                    state_d = WAIT_ONES;
                end
            endcase
        end else if (state_q == WAIT_TENS) begin
            if (timer_q == TMO_LAST) begin
                err_d   = 1'b1;
                state_d = WAIT_ONES;
            end else begin
                timer_d = timer_q + 8'd1;
            end
        end

`ifdef SEVENSEG_READER_STABLE_EN
        // Publish only on two consecutive good frames with equal value.
        if (good) begin
            if (cand_vld_q && cand_q == value[3:0]) begin
                v_out_d = value[3:0];
                valid_d = 1'b1;
            end else begin
                cand_d     = value[3:0];
                cand_vld_d = 1'b1;
            end
        end
        if (err_d) cand_vld_d = 1'b0;
`else
        if (good) begin
            v_out_d = value[3:0];
            valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= WAIT_ONES;
            ones_q  <= 4'd0;
            timer_q <= 8'd0;
            v_out_q <= 4'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef SEVENSEG_READER_STABLE_EN
            cand_q     <= 4'd0;
            cand_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            timer_q <= timer_d;
            v_out_q <= v_out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
`ifdef SEVENSEG_READER_STABLE_EN
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
`endif
        end
    end

    assign bus.v_out = v_out_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
    assign bus.busy  = (state_q == WAIT_TENS);

endmodule

// File: tb/tb_sevenseg_reader.sv
// ---------------------------------------------------------------------------
// tb_sevenseg_reader
// Directed vectors with hand-computed expectations for sevenseg_reader
// (TIMEOUT = 16, active-high segments). Inputs change 1 ns after the rising
// edge; outputs are checked at that same point, i.e. after the edge settled.
// ---------------------------------------------------------------------------
module tb_sevenseg_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sevenseg_reader_if ifc ();

    sevenseg_reader #(.TIMEOUT(16), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] seg, input logic [1:0] sel);
        ifc.seg_in  = seg;
        ifc.dig_sel = sel;
        ifc.strobe  = 1'b1;
    endtask

    task automatic idle();
        ifc.strobe  = 1'b0;
        ifc.seg_in  = 7'h00;
        ifc.dig_sel = 2'b00;
    endtask

    // Ones then tens on consecutive cycles, check pulse and held value.
    task automatic frame(input string tag, input logic [6:0] o, input logic [6:0] t,
                         input logic ev, input logic ee, input logic [3:0] evo);
        drive(o, 2'b01); tick();
        chk({tag, " busy_mid"}, ifc.busy, 1);
        drive(t, 2'b10); tick();
        idle();
        chk({tag, " valid"}, ifc.valid, ev);
        chk({tag, " err"},   ifc.err,   ee);
        chk({tag, " v_out"}, ifc.v_out, evo);
        chk({tag, " busy"},  ifc.busy,  0);
        tick();
        chk({tag, " valid_end"}, ifc.valid, 0);
        chk({tag, " err_end"},   ifc.err,   0);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst v_out", ifc.v_out, 0);
        chk("rst valid", ifc.valid, 0);
        chk("rst err",   ifc.err,   0);
        chk("rst busy",  ifc.busy,  0);
        tick();

`ifdef SEVENSEG_READER_STABLE_EN
        frame("s3a", 7'h4F, 7'h00, 0, 0, 4'd0);
        frame("s3b", 7'h4F, 7'h3F, 1, 0, 4'd3);
        frame("s5a", 7'h6D, 7'h00, 0, 0, 4'd3);
        frame("s5b", 7'h6D, 7'h00, 1, 0, 4'd5);
`else
        frame("f15", 7'h6D, 7'h06, 1, 0, 4'd15);
        frame("f8b", 7'h7F, 7'h00, 1, 0, 4'd8);
        frame("f8z", 7'h7F, 7'h3F, 1, 0, 4'd8);
        frame("f16", 7'h7D, 7'h06, 0, 1, 4'd8);
        frame("fbadt", 7'h06, 7'h5B, 0, 1, 4'd8);

        // Ones restart: 1 replaced by 3, tens blank -> 3
        drive(7'h06, 2'b01); tick();
        frame("restart", 7'h4F, 7'h00, 1, 0, 4'd3);

        // Timeout: ones accepted at this edge, err 16 cycles after strobe cycle
        drive(7'h5B, 2'b01); tick();
        idle();
        for (int k = 1; k < 16; k++) begin
            chk($sformatf("tmo err c%0d", k), ifc.err, 0);
            if (k == 15) chk("tmo busy c15", ifc.busy, 1);
            tick();
        end
        chk("tmo err",   ifc.err,   1);
        chk("tmo busy",  ifc.busy,  0);
        chk("tmo valid", ifc.valid, 0);
        chk("tmo v_out", ifc.v_out, 3);
        tick();
        chk("tmo err_end", ifc.err, 0);

        // Illegal ones pattern
        drive(7'h49, 2'b01); tick(); idle();
        chk("ill err",  ifc.err,  1);
        chk("ill busy", ifc.busy, 0);
        tick();

        // Tens-only strobe in WAIT_ONES is ignored
        drive(7'h06, 2'b10); tick(); idle();
        chk("tonly err",   ifc.err,   0);
        chk("tonly valid", ifc.valid, 0);
        chk("tonly busy",  ifc.busy,  0);
        tick();

        // Bad digit select aborts a held frame
        drive(7'h06, 2'b01); tick();
        drive(7'h3F, 2'b11); tick(); idle();
        chk("sel11 err",  ifc.err,  1);
        chk("sel11 busy", ifc.busy, 0);
        tick();
`endif

        // Reset mid-frame drops the held digit and produces no pulse
        drive(7'h4F, 2'b01); tick(); idle();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstmid busy", ifc.busy, 0);
        drive(7'h00, 2'b10); tick(); idle();
        chk("rstmid valid", ifc.valid, 0);
        chk("rstmid err",   ifc.err,   0);
        chk("rstmid v_out", ifc.v_out, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
